// File: rtl/sha256_digest_serializer.sv
// Streams a captured 256-bit SHA-256 digest out one WORD_W beat at a time, H0 first.
// Latency: load_i sampled at edge N -> first word valid from cycle N+1; done_o pulses one cycle after the last transfer.
// Backpressure: valid/ready; word/idx/last hold while ready_i=0. SHA256_SER_BSWAP_EN byte-reverses word_o.
module sha256_digest_serializer #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        load_i,
  input  logic [WORD_W*NUM_WORDS-1:0] digest_i,
  output logic                        busy_o,
  output logic [WORD_W-1:0]           word_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic                        last_o,
  output logic [$clog2(NUM_WORDS)-1:0] idx_o,
  output logic                        done_o
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int BUF_W = WORD_W * NUM_WORDS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [BUF_W-1:0]  buf_q,   buf_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [WORD_W-1:0] cur_word;

  // State, shift buffer and word index registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: capture in IDLE, shift out on each accepted beat, one DONE cycle.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (load_i) begin
          buf_d   = digest_i;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // valid_o is always high here, so ready_i alone marks a transfer.
        if (ready_i) begin
          buf_d = {buf_q[BUF_W-WORD_W-1:0], {WORD_W{1'b0}}};
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode, purely from registers; optional byte reversal for little-endian hosts.
  always_comb begin
    cur_word = buf_q[BUF_W-1 -: WORD_W];
    word_o   = '0;
`ifdef SHA256_SER_BSWAP_EN
    for (int b = 0; b < WORD_W / 8; b++) begin
      word_o[8*b +: 8] = cur_word[WORD_W-8-8*b +: 8];
    end
`else
    word_o = cur_word;
`endif
    busy_o  = (state_q != IDLE);
    valid_o = (state_q == SEND);
    last_o  = (state_q == SEND) && (idx_q == LAST_IDX);
    done_o  = (state_q == DONE);
    idx_o   = idx_q;
  end

endmodule

// File: tb/tb_sha256_digest_serializer.sv
// Directed bench for sha256_digest_serializer with a scoreboard of expected beats.
// Expected words are queued at load time and popped on every valid&&ready handshake.
// Covers reset, full-rate streaming, backpressure, ignored load, mid-stream reset, byte swap.
module tb_sha256_digest_serializer;

  logic         CLK;
  logic         RST;
  logic         load_i;
  logic [255:0] digest_i;
  logic         busy_o;
  logic [31:0]  word_o;
  logic         valid_o;
  logic         ready_i;
  logic         last_o;
  logic [2:0]   idx_o;
  logic         done_o;

  sha256_digest_serializer #(.WORD_W(32), .NUM_WORDS(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .load_i   (load_i),
    .digest_i (digest_i),
    .busy_o   (busy_o),
    .word_o   (word_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .last_o   (last_o),
    .idx_o    (idx_o),
    .done_o   (done_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] word;
    logic [2:0]  idx;
    logic        last;
  } beat_t;

  beat_t sb_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;

  // Snapshot of DUT outputs taken at the falling edge of the last tick.
  logic        obs_valid, obs_done, obs_busy, obs_last;
  logic [31:0] obs_word;
  logic [2:0]  obs_idx;

  // Stall tracking for hold-stability checks.
  logic        stall_pending = 1'b0;
  logic [31:0] stall_word;
  logic [2:0]  stall_idx;
  logic        stall_last;

  localparam logic [255:0] ABC_DIGEST =
    256'hBA7816BF_8F01CFEA_414140DE_5DAE2223_B00361A3_96177A9C_B410FF61_F20015AD;
  localparam logic [255:0] PAT_DIGEST =
    256'h01234567_89ABCDEF_DEADBEEF_0BADF00D_11223344_55667788_99AABBCC_DDEEFF00;
  localparam logic [255:0] ALT_DIGEST =
    256'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C_0F0F0F0F_F0F0F0F0_12345678_87654321;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef SHA256_SER_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic push_digest(input logic [255:0] d);
    beat_t e;
    for (int i = 0; i < 8; i++) begin
      e.word = exp_word(d[255-32*i -: 32]);
      e.idx  = 3'(i);
      e.last = (i == 7);
      sb_q.push_back(e);
    end
  endtask

  // One clock: sample/score at the falling edge, then step past the rising edge.
  task automatic tick();
    beat_t e;
    @(negedge CLK);
    obs_valid = valid_o;
    obs_done  = done_o;
    obs_busy  = busy_o;
    obs_last  = last_o;
    obs_word  = word_o;
    obs_idx   = idx_o;
    if (stall_pending) begin
      check("hold_word", word_o, stall_word);
      check("hold_idx", 32'(idx_o), 32'(stall_idx));
      check("hold_last", 32'(last_o), 32'(stall_last));
      check("hold_valid", 32'(valid_o), 32'd1);
    end
    if (valid_o && ready_i) begin
      if (sb_q.size() == 0) begin
        check("unexpected_beat", 32'(idx_o), 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check("word", word_o, e.word);
        check("idx", 32'(idx_o), 32'(e.idx));
        check("last", 32'(last_o), 32'(e.last));
      end
    end
    stall_pending = valid_o && !ready_i;
    stall_word    = word_o;
    stall_idx     = idx_o;
    stall_last    = last_o;
    if (done_o) done_cnt++;
    @(posedge CLK);
    #1;
  endtask

  // Run until every queued beat is consumed and done_o has been seen, bounded.
  task automatic drain(input int pattern);
    int guard;
    int k;
    guard = 0;
    k = 0;
    while (!(sb_q.size() == 0 && done_cnt > 0) && guard < 200) begin
      ready_i = (pattern == 0) ? 1'b1 : ((k % 3) == 0);
      tick();
      k++;
      guard++;
    end
    check("drain_timeout", 32'(guard < 200), 32'd1);
    ready_i = 1'b1;
    tick();
    tick();
    check("done_once", 32'(done_cnt), 32'd1);
    check("idle_after", 32'(busy_o), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(busy_o),  32'd0);
    check({tag, "_word"},  word_o,       32'd0);
    check({tag, "_valid"}, 32'(valid_o), 32'd0);
    check({tag, "_last"},  32'(last_o),  32'd0);
    check({tag, "_idx"},   32'(idx_o),   32'd0);
    check({tag, "_done"},  32'(done_o),  32'd0);
  endtask

  initial begin
    int guard;
    RST      = 1'b1;
    load_i   = 1'b0;
    digest_i = '0;
    ready_i  = 1'b0;

    // 1. Reset, then idle with no load.
    tick();
    tick();
    check_all_zero("reset");
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_valid", 32'(obs_valid), 32'd0);
    end
    check("idle_busy", 32'(obs_busy), 32'd0);

    // 2. "abc" digest at full rate with cycle-accurate timing.
    ready_i  = 1'b1;
    digest_i = ABC_DIGEST;
    load_i   = 1'b1;
    push_digest(ABC_DIGEST);
    done_cnt = 0;
    tick();
    load_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("s2_valid", 32'(obs_valid), 32'd1);
      check("s2_last_pos", 32'(obs_last), 32'(k == 7));
      check("s2_nodone", 32'(obs_done), 32'd0);
    end
    check("s2_first_word_fmt", exp_word(32'hBA7816BF),
`ifdef SHA256_SER_BSWAP_EN
          32'hBF1678BA
`else
          32'hBA7816BF
`endif
    );
    check("s2_last_word", obs_word, exp_word(32'hF20015AD));
    tick();
    check("s2_done", 32'(obs_done), 32'd1);
    check("s2_done_valid", 32'(obs_valid), 32'd0);
    check("s2_done_busy", 32'(obs_busy), 32'd1);
    tick();
    check("s2_busy_low", 32'(obs_busy), 32'd0);
    check("s2_done_pulse", 32'(obs_done), 32'd0);
    check("s2_sb_empty", 32'(sb_q.size()), 32'd0);
    check("s2_done_cnt", 32'(done_cnt), 32'd1);

    // 3. Backpressure pattern 1,0,0,1,...
    digest_i = PAT_DIGEST;
    load_i   = 1'b1;
    push_digest(PAT_DIGEST);
    done_cnt = 0;
    tick();
    load_i = 1'b0;
    drain(1);

    // 4. Load with all-ones digest while streaming at idx 3 must be ignored.
    digest_i = ABC_DIGEST;
    load_i   = 1'b1;
    ready_i  = 1'b1;
    push_digest(ABC_DIGEST);
    done_cnt = 0;
    tick();
    load_i = 1'b0;
    guard = 0;
    while (idx_o != 3'd3 && guard < 20) begin
      tick();
      guard++;
    end
    check("s4_reach_idx3", 32'(idx_o), 32'd3);
    digest_i = {256{1'b1}};
    load_i   = 1'b1;
    tick();
    tick();
    load_i   = 1'b0;
    drain(0);

    // 5. Reset mid-stream at idx 5: immediate clear, no done, clean restart.
    digest_i = ALT_DIGEST;
    load_i   = 1'b1;
    push_digest(ALT_DIGEST);
    done_cnt = 0;
    tick();
    load_i = 1'b0;
    guard = 0;
    while (idx_o != 3'd5 && guard < 20) begin
      tick();
      guard++;
    end
    check("s5_reach_idx5", 32'(idx_o), 32'd5);
    #2;
    RST = 1'b1;
    #1;
    check_all_zero("s5_rst");
    sb_q.delete();
    stall_pending = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    tick();
    tick();
    tick();
    check("s5_no_done", 32'(done_cnt), 32'd0);
    check("s5_idle_valid", 32'(obs_valid), 32'd0);
    digest_i = PAT_DIGEST;
    load_i   = 1'b1;
    push_digest(PAT_DIGEST);
    tick();
    load_i = 1'b0;
    tick();
    check("s5_restart_idx", 32'(obs_idx), 32'd0);
    check("s5_restart_valid", 32'(obs_valid), 32'd1);
    drain(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
